// File: rtl/slider_switch_poller.sv
// slider_switch_poller: polls the switch PIO over Avalon-MM, debounces the
// switch vector, latches per-bit change events and raises a maskable irq.
//
// Ports:
//   clk, reset_n             system clock, async active-low reset
//   m_address, m_read        master strobe to the switch PIO (address fixed 0)
//   m_readdata               PIO data, valid the cycle after m_read
//   s_address, s_read,       CPU slave port: 0 STATE, 1 CTRL, 2 EDGE (W1C),
//   s_write, s_writedata     3 MASK
//   s_readdata               registered read data, latency 1
//   irq                      level interrupt: irq_en & |(EDGE & MASK)
module slider_switch_poller #(
    parameter int WIDTH      = 10,
    parameter int POLL_DIV   = 50000,
    parameter int DEBOUNCE_N = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        irq
);

    localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int CW = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(POLL_DIV - 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_N - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPTURE
    } state_t;

    state_t           state;
    logic [TW-1:0]    timer;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] candidate;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] mask;
    logic             poll_en;
    logic             irq_en;

    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] cand_nxt;
    logic [CW-1:0]    count_nxt;
    logic             accept;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic             unused_bits;

    assign m_address   = 2'b00;
    assign sample      = m_readdata[WIDTH-1:0];
    assign unused_bits = ^{m_readdata, s_writedata};

    // Debounce step, only committed in CAPTURE. A new value restarts the
    // run; a repeated value extends it up to the acceptance threshold.
    always_comb begin
        cand_nxt  = candidate;
        count_nxt = count;
        if (sample != candidate) begin
            cand_nxt  = sample;
            count_nxt = '0;
        end else if (count != C_LAST) begin
            count_nxt = count + CW'(1);
        end
        accept   = (state == CAPTURE) && (count_nxt == C_LAST)
                   && (cand_nxt != stable);
        edge_set = accept ? (stable ^ cand_nxt) : '0;
    end

    // Poll sequencer. poll_en only gates the IDLE timer, so a transaction
    // already in flight always completes before the FSM parks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            timer     <= '0;
            m_read    <= 1'b0;
            candidate <= '0;
            count     <= '0;
            stable    <= '0;
        end else begin
            m_read <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!poll_en) begin
                        timer <= '0;
                    end else if (timer == T_LAST) begin
                        timer  <= '0;
                        state  <= READ;
                        m_read <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                READ: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    candidate <= cand_nxt;
                    count     <= count_nxt;
                    if (accept) begin
                        stable <= cand_nxt;
                    end
                    timer <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign edge_clr = (s_write && (s_address == 2'd2))
                      ? s_writedata[WIDTH-1:0] : '0;

    // CPU register file. Reads sample pre-write values; a new edge beats
    // a same-cycle W1C on the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_en    <= 1'b0;
            irq_en     <= 1'b0;
            mask       <= '0;
            edge_q     <= '0;
            s_readdata <= '0;
        end else begin
            if (s_read) begin
                unique case (s_address)
                    2'd0: s_readdata <= 32'(stable);
                    2'd1: s_readdata <= 32'({irq_en, poll_en});
                    2'd2: s_readdata <= 32'(edge_q);
                    2'd3: s_readdata <= 32'(mask);
                endcase
            end
            if (s_write && (s_address == 2'd1)) begin
                poll_en <= s_writedata[0];
                irq_en  <= s_writedata[1];
            end
            if (s_write && (s_address == 2'd3)) begin
                mask <= s_writedata[WIDTH-1:0];
            end
            edge_q <= (edge_q & ~edge_clr) | edge_set;
        end
    end

    assign irq = irq_en & (|(edge_q & mask));

endmodule

// File: tb/tb_slider_switch_poller.sv
// tb_slider_switch_poller: directed and randomized checks of the switch
// poller against a history-based debounce model and a PIO responder.
module tb_slider_switch_poller;

    localparam int W  = 10;
    localparam int PD = 4;
    localparam int DN = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  m_address;
    logic        m_read;
    logic [31:0] m_readdata = '0;
    logic [1:0]  s_address = '0;
    logic        s_read = 1'b0;
    logic        s_write = 1'b0;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic        irq;

    slider_switch_poller #(
        .WIDTH(W),
        .POLL_DIV(PD),
        .DEBOUNCE_N(DN)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .m_address(m_address),
        .m_read(m_read),
        .m_readdata(m_readdata),
        .s_address(s_address),
        .s_read(s_read),
        .s_write(s_write),
        .s_writedata(s_writedata),
        .s_readdata(s_readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: stable follows a value once the last DN captured
    // samples all equal it (reset behaves as one prior sample of zero).
    logic [W-1:0] sw = '0;
    logic [W-1:0] hist[$];
    logic [W-1:0] m_stable;
    logic [W-1:0] m_edge;
    logic [W-1:0] m_mask;
    logic [1:0]   m_ctrl;

    function automatic void model_reset();
        hist.delete();
        hist.push_back('0);
        m_stable = '0;
        m_edge   = '0;
        m_mask   = '0;
        m_ctrl   = '0;
    endfunction

    function automatic void model_capture(input logic [W-1:0] s);
        bit same;
        same = 1'b1;
        hist.push_back(s);
        if (hist.size() > DN) void'(hist.pop_front());
        if (hist.size() < DN) return;
        foreach (hist[i]) if (hist[i] != s) same = 1'b0;
        if (same && (s != m_stable)) begin
            m_edge   = m_edge | (m_stable ^ s);
            m_stable = s;
        end
    endfunction

    function automatic logic [31:0] model_reg(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_stable);
            2'd1:    return 32'(m_ctrl);
            2'd2:    return 32'(m_edge);
            default: return 32'(m_mask);
        endcase
    endfunction

    function automatic logic model_irq();
        return m_ctrl[1] & (|(m_edge & m_mask));
    endfunction

    function automatic void model_write(input logic [1:0] a,
                                        input logic [31:0] d);
        case (a)
            2'd1:    m_ctrl = d[1:0];
            2'd2:    m_edge = m_edge & ~d[W-1:0];
            2'd3:    m_mask = d[W-1:0];
            default: ;
        endcase
    endfunction

    // PIO responder: data valid only in the cycle after m_read, garbage
    // otherwise; the model captures on the same edge the DUT does.
    logic         cap_pend = 1'b0;
    logic [W-1:0] cap_val = '0;
    always @(posedge clk or negedge reset_n) begin : pio
        logic [31:0] word;
        if (!reset_n) begin
            cap_pend = 1'b0;
        end else begin
            if (cap_pend) model_capture(cap_val);
            cap_pend = m_read;
            cap_val  = sw;
            word = $urandom;
            if (m_read) word[W-1:0] = sw;
            m_readdata <= word;
        end
    end

    int cyc = 0;
    int rd_q[$];
    int addr_bad = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (m_read) rd_q.push_back(cyc);
        if (m_address !== 2'b00) addr_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        s_address   = a;
        s_writedata = d;
        s_write     = 1'b1;
        model_write(a, d);
        tick();
        s_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        s_address = a;
        s_read    = 1'b1;
        tick();
        s_read = 1'b0;
        d = s_readdata;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a);
        logic [31:0] exp;
        logic [31:0] d;
        exp = model_reg(a);
        rd(a, d);
        chk(tag, d, exp);
    endtask

    // Returns in the CAPTURE cycle of the next poll.
    task automatic wait_read(input string tag);
        int n0;
        int k;
        n0 = rd_q.size();
        k  = 0;
        while ((rd_q.size() == n0) && (k < 40)) begin
            tick();
            k++;
        end
        chk(tag, 32'(rd_q.size() > n0), 32'd1);
    endtask

    // Returns just after the capture edge of the next poll.
    task automatic wait_poll(input string tag);
        wait_read(tag);
        tick();
    endtask

    initial begin
        logic [31:0] v;
        int c0;
        int n;

        model_reset();
        reset_n = 1'b0;
        tick(3);
        chk("rst_m_read", m_read, 0);
        chk("rst_irq", irq, 0);
        chk("rst_readdata", s_readdata, 0);
        reset_n = 1'b1;
        tick(2);
        rd_chk("rst_state", 2'd0);
        rd_chk("rst_ctrl", 2'd1);
        rd_chk("rst_edge", 2'd2);
        rd_chk("rst_mask", 2'd3);
        tick(20);
        chk("no_poll_disabled", rd_q.size(), 0);

        // Poll timing and basic debounce of 0x2A5.
        sw = 10'h2A5;
        wr(2'd1, 32'h1);
        c0 = cyc;
        wait_poll("poll1");
        rd_chk("db_state_p1", 2'd0);
        wait_poll("poll2");
        rd(2'd0, v);
        chk("db_state_p2", v, 32'h0);
        wait_poll("poll3");
        rd(2'd0, v);
        chk("db_state_p3", v, 32'h2A5);
        rd(2'd2, v);
        chk("db_edge_p3", v, 32'h2A5);
        chk("db_irq_masked", irq, 0);
        chk("first_read_lat", rd_q[0] - c0, PD);
        chk("period1", rd_q[1] - rd_q[0], PD + 2);
        chk("period2", rd_q[2] - rd_q[1], PD + 2);

        // Bouncing bit0, then held.
        sw = 10'h000;
        repeat (3) wait_poll("settle0");
        rd_chk("settle0_state", 2'd0);
        for (int i = 0; i < 5; i++) begin
            sw = (i % 2 == 0) ? 10'h001 : 10'h000;
            wait_poll("bounce");
            rd_chk("bounce_state", 2'd0);
        end
        sw = 10'h001;
        wait_poll("hold2");
        rd(2'd0, v);
        chk("hold2_state", v, 32'h0);
        wait_poll("hold3");
        rd(2'd0, v);
        chk("hold3_state", v, 32'h1);

        // Interrupt set, W1C clear, and W1C colliding with a new edge.
        wr(2'd3, 32'h1);
        wr(2'd1, 32'h3);
        wr(2'd2, 32'h3FF);
        chk("irq_cleared", irq, 0);
        sw = 10'h000;
        wait_poll("irq_p1");
        wait_poll("irq_p2");
        chk("irq_before", irq, 0);
        wait_poll("irq_p3");
        chk("irq_set", irq, 1);
        wr(2'd2, 32'h1);
        chk("irq_w1c", irq, 0);
        sw = 10'h001;
        wait_poll("col_p1");
        wait_poll("col_p2");
        wait_read("col_p3");
        wr(2'd2, 32'h1);
        chk("collide_irq", irq, 1);
        rd(2'd2, v);
        chk("collide_edge", v & 32'h1, 32'h1);
        rd_chk("collide_edge_model", 2'd2);

        // Simultaneous read/write, read hold, ignored STATE write.
        s_address   = 2'd3;
        s_writedata = 32'h155;
        s_read      = 1'b1;
        s_write     = 1'b1;
        v = model_reg(2'd3);
        model_write(2'd3, 32'h155);
        tick();
        s_read  = 1'b0;
        s_write = 1'b0;
        chk("rw_pre_value", s_readdata, v);
        rd_chk("rw_mask_written", 2'd3);
        v = s_readdata;
        tick(3);
        chk("readdata_hold", s_readdata, v);
        wr(2'd0, 32'h3FF);
        rd_chk("state_write_ignored", 2'd0);

        // Asynchronous reset in the middle of a READ.
        n = 0;
        while ((m_read !== 1'b1) && (n < 40)) begin
            @(negedge clk);
            n++;
        end
        chk("found_read", m_read, 1);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_drop", m_read, 0);
        chk("async_irq", irq, 0);
        tick(2);
        reset_n = 1'b1;
        tick();
        rd_chk("rr_state", 2'd0);
        rd_chk("rr_ctrl", 2'd1);
        rd_chk("rr_edge", 2'd2);
        rd_chk("rr_mask", 2'd3);
        n = rd_q.size();
        tick(20);
        chk("no_poll_after_reset", rd_q.size(), n);
        wr(2'd1, 32'hFFFF_FFFD);
        c0 = cyc;
        rd_chk("ctrl_upper_zero", 2'd1);
        wait_read("resume");
        chk("resume_latency", rd_q[rd_q.size() - 1] - c0, PD);
        tick();

        // Randomized switch patterns, masks and W1C writes.
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 1) == 1)
                sw = W'($urandom);
            else
                sw = m_stable ^ (W'(1) << $urandom_range(0, W - 1));
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                wait_poll("rand_poll");
                chk("rand_irq", irq, model_irq());
                case ($urandom_range(0, 3))
                    0: wr(2'd2, $urandom);
                    1: wr(2'd3, $urandom);
                    2: wr(2'd1, $urandom | 32'h1);
                    default: ;
                endcase
                chk("rand_irq_w", irq, model_irq());
                rd_chk("rand_state", 2'd0);
                rd_chk("rand_edge", 2'd2);
            end
        end

        chk("m_address_zero", addr_bad, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
